// File: rtl/debug_dump_tx.sv
// Debug link transmitter: streams a PC/ACC/CYC snapshot and the first N_WORDS DM words to uart_tx.
// Optional trailing XOR checksum byte when DUMP_CHECKSUM_EN is defined.
module debug_dump_tx #(
    parameter int              SIZE    = 8,
    parameter int              DATA_W  = 16,
    parameter int              ADDR_W  = 11,
    parameter int              N_WORDS = 16,
    parameter logic [SIZE-1:0] HDR     = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] acc,
    input  logic [15:0]       cycles,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              tx_done,
    output logic [ADDR_W-1:0] dm_raddr,
    output logic              dm_rd,
    output logic              tx_start,
    output logic [SIZE-1:0]   d_out,
    output logic              busy,
    output logic              done
);

    localparam int DM_END = 7 + 2 * N_WORDS;
`ifdef DUMP_CHECKSUM_EN
    localparam int N_BYTES = DM_END + 1;
`else
    localparam int N_BYTES = DM_END;
`endif
    localparam int BW   = $clog2(N_BYTES + 1);
    localparam int WW   = ADDR_W + 1;
    localparam int HV_W = 16 + 2 * DATA_W + SIZE;

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        SEND,
        WAIT,
        RDREQ,
        RDWAIT,
        FIN
    } state_t;

    state_t state, state_n;

    logic [BW-1:0]     byte_idx;
    logic [BW-1:0]     nxt_idx;
    logic [WW-1:0]     word_idx;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] acc_q;
    logic [15:0]       cyc_q;
    logic [DATA_W-1:0] word_q;
    logic [HV_W-1:0]   hdr_vec;
    logic [SIZE-1:0]   cur_byte;
    logic              in_hdr;
    logic              in_dm;
    logic              next_is_lo;
`ifdef DUMP_CHECKSUM_EN
    logic [SIZE-1:0]   csum;
`endif

    assign nxt_idx    = byte_idx + BW'(1);
    assign next_is_lo = (nxt_idx >= BW'(7)) && nxt_idx[0]
                        && (nxt_idx < BW'(DM_END));

    // Header bytes 0..6 come straight out of this vector, lowest byte first.
    assign hdr_vec = {cyc_q, acc_q, pc_q, HDR};
    assign in_hdr  = byte_idx < BW'(7);
    assign in_dm   = !in_hdr && (byte_idx < BW'(DM_END));

    always_comb begin
        cur_byte = '0;
        unique case (1'b1)
            in_hdr:  cur_byte = hdr_vec[SIZE*int'(byte_idx[2:0]) +: SIZE];
            in_dm:   cur_byte = byte_idx[0] ? word_q[SIZE-1:0]
                                            : word_q[DATA_W-1:SIZE];
`ifdef DUMP_CHECKSUM_EN
            default: cur_byte = csum;
`else
            default: cur_byte = '0;
`endif
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        tx_start = 1'b0;
        dm_rd    = 1'b0;
        dm_raddr = '0;
        done     = 1'b0;
        busy     = (state != IDLE);
        d_out    = '0;
        unique case (state)
            IDLE: begin
                if (start) state_n = SNAP;
            end
            SNAP: state_n = SEND;
            SEND: begin
                tx_start = 1'b1;
                d_out    = cur_byte;
                state_n  = WAIT;
            end
            WAIT: begin
                d_out = cur_byte;
                if (tx_done) begin
                    if (nxt_idx == BW'(N_BYTES)) state_n = FIN;
                    else if (next_is_lo)         state_n = RDREQ;
                    else                         state_n = SEND;
                end
            end
            RDREQ: begin
                dm_rd    = 1'b1;
                dm_raddr = word_idx[ADDR_W-1:0];
                state_n  = RDWAIT;
            end
            RDWAIT: state_n = SEND;
            FIN: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_idx <= '0;
            word_idx <= '0;
            pc_q     <= '0;
            acc_q    <= '0;
            cyc_q    <= '0;
            word_q   <= '0;
`ifdef DUMP_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            if (state == SNAP) begin
                pc_q     <= DATA_W'(pc);
                acc_q    <= acc;
                cyc_q    <= cycles;
                byte_idx <= '0;
                word_idx <= '0;
`ifdef DUMP_CHECKSUM_EN
                csum     <= '0;
`endif
            end
            if (state == WAIT && tx_done) byte_idx <= nxt_idx;
            // Hi byte reuses this latched word, so each DM word is read once.
            if (state == RDWAIT) begin
                word_q   <= dm_rdata;
                word_idx <= word_idx + WW'(1);
            end
`ifdef DUMP_CHECKSUM_EN
            if (state == SEND) csum <= csum ^ cur_byte;
`endif
        end
    end

endmodule

// File: tb/tb_debug_dump_tx.sv
// Scoreboard bench for debug_dump_tx: random snapshots/DM contents, emulated uart_tx and DM.
// Expected frames are built from the frame layout and queued; a negedge monitor pops and compares.
module tb_debug_dump_tx;

    localparam int NW = 4;
`ifdef DUMP_CHECKSUM_EN
    localparam int NB = 8 + 2 * NW;
`else
    localparam int NB = 7 + 2 * NW;
`endif

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        start    = 1'b0;
    logic [10:0] pc       = '0;
    logic [15:0] acc      = '0;
    logic [15:0] cycles   = '0;
    logic [15:0] dm_rdata = '0;
    logic        tx_done  = 1'b0;
    logic [10:0] dm_raddr;
    logic        dm_rd;
    logic        tx_start;
    logic [7:0]  d_out;
    logic        busy;
    logic        done;

    logic [15:0] mem [NW];
    logic [7:0]  expq [$];
    logic [7:0]  lit [15] = '{8'hA5, 8'h23, 8'h01, 8'hEF, 8'hBE, 8'h42, 8'h00,
                             8'h00, 8'h11, 8'h01, 8'h11, 8'h02, 8'h11, 8'h03, 8'h11};

    int   total = 0;
    int   bad   = 0;
    int   starts = 0;
    int   dones  = 0;
    int   dly_min = 0;
    int   dly_max = 0;
    bit   pend = 1'b0;
    int   cnt  = 0;
    logic [7:0] held = '0;

    always #5 clk = ~clk;

    debug_dump_tx #(.N_WORDS(NW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .pc       (pc),
        .acc      (acc),
        .cycles   (cycles),
        .dm_rdata (dm_rdata),
        .tx_done  (tx_done),
        .dm_raddr (dm_raddr),
        .dm_rd    (dm_rd),
        .tx_start (tx_start),
        .d_out    (d_out),
        .busy     (busy),
        .done     (done)
    );

    always @(posedge clk) begin
        if (dm_rd) dm_rdata <= mem[dm_raddr[1:0]];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Frame = header, snapshot words lo/hi, DM words lo/hi, optional XOR of all before it.
    function automatic void push_frame(input logic [10:0] p, input logic [15:0] a,
                                       input logic [15:0] c, input bit use_lit);
        logic [7:0]  b [$];
        logic [15:0] p16;
        logic [7:0]  x;
        p16 = {5'b0, p};
        if (use_lit) begin
            foreach (lit[i]) b.push_back(lit[i]);
        end else begin
            b.push_back(8'hA5);
            b.push_back(p16[7:0]);
            b.push_back(p16[15:8]);
            b.push_back(a[7:0]);
            b.push_back(a[15:8]);
            b.push_back(c[7:0]);
            b.push_back(c[15:8]);
            for (int i = 0; i < NW; i++) begin
                b.push_back(mem[i][7:0]);
                b.push_back(mem[i][15:8]);
            end
        end
`ifdef DUMP_CHECKSUM_EN
        x = 8'h00;
        foreach (b[i]) x = x ^ b[i];
        b.push_back(x);
`else
        x = 8'h00;
`endif
        foreach (b[i]) expq.push_back(b[i]);
    endfunction

    // uart_tx stand-in plus scoreboard consumer.
    always @(negedge clk) begin
        tx_done = 1'b0;
        if (!reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (cnt == 0) begin
                    tx_done = 1'b1;
                    pend    = 1'b0;
                    chk("d_out_hold", d_out, held);
                end else begin
                    cnt--;
                end
            end
            if (tx_start) begin
                starts++;
                chk("one_start_per_byte", pend, 0);
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_byte: got %0h want none", d_out);
                end else begin
                    chk("byte", d_out, expq.pop_front());
                end
                pend = 1'b1;
                held = d_out;
                cnt  = int'($urandom_range(dly_max, dly_min));
            end
            if (done) dones++;
            if (dm_rd) chk("dm_addr_range", dm_raddr < NW, 1);
        end
    end

    task automatic run_frame(input bit use_lit, input int dmin, input int dmax,
                             input int abort_at);
        int s0;
        int d0;
        bit mid;
        bit fin;
        dly_min = dmin;
        dly_max = dmax;
        if (use_lit) begin
            pc     = 11'h123;
            acc    = 16'hBEEF;
            cycles = 16'h0042;
            for (int i = 0; i < NW; i++) mem[i] = 16'h1100 + 16'(i);
        end else begin
            pc     = 11'($urandom);
            acc    = 16'($urandom);
            cycles = 16'($urandom);
            for (int i = 0; i < NW; i++) mem[i] = 16'($urandom);
        end
        expq.delete();
        push_frame(pc, acc, cycles, use_lit);
        s0 = starts;
        d0 = dones;
        @(negedge clk); #1;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        chk("busy_in_snap", busy, 1);
        @(negedge clk); #1;
        chk("start_latency", tx_start, 1);
        pc     = 11'($urandom);
        acc    = 16'($urandom);
        cycles = 16'($urandom);
        mid = 1'b0;
        fin = 1'b0;
        for (int k = 0; k < 4000 && !fin; k++) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (!mid && (starts - s0) >= 3) begin
                start = 1'b1;
                mid   = 1'b1;
            end
            if (abort_at > 0 && (starts - s0) >= abort_at) begin
                reset = 1'b0;
                start = 1'b0;
                @(negedge clk); #1;
                chk("abort_tx_start", tx_start, 0);
                chk("abort_busy", busy, 0);
                reset = 1'b1;
                expq.delete();
                return;
            end
            if (dones != d0) fin = 1'b1;
        end
        start = 1'b0;
        chk("done_once", dones - d0, 1);
        chk("tx_count", starts - s0, NB);
        chk("queue_empty", expq.size(), 0);
        @(negedge clk); #1;
        chk("busy_after_done", busy, 0);
        repeat (4) @(negedge clk);
        chk("no_requeue", starts - s0, NB);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_dm_rd", dm_rd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_d_out", d_out, 0);
        chk("rst_dm_raddr", dm_raddr, 0);
        #1 start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk); #1;
        chk("reset_beats_start", busy, 0);
        run_frame(1'b1, 0, 3, 0);
        repeat (3) run_frame(1'b0, 0, 2, 0);
        run_frame(1'b0, 100, 100, 0);
        run_frame(1'b0, 0, 1, 5);
        run_frame(1'b0, 0, 3, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
